// File: rtl/prog_instruction_memory.sv
// rtl/prog_instruction_memory.sv - loadable instruction memory with registered fetch port,
// word-serial load port and a post-reset NOP clear sweep.
module prog_instruction_memory #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 1024,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ready,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_valid,
  output logic [DATA_WIDTH-1:0] fetch_instr,
  output logic                  fetch_fault,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH-1:0] load_base,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  load_done
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_LOAD} state_t;

  state_t                state, state_next;
  logic [IDX_W-1:0]      clr_ptr;
  logic [IDX_W-1:0]      wr_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  mem_we;
  logic [IDX_W-1:0]      mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  beat;
  logic                  fetch_take;
  logic                  fault;
  logic [IDX_W-1:0]      fetch_idx;
  logic                  unused_base_bits;

  assign fetch_idx = fetch_addr[IDX_W+1:2];
  // Any set bit above the word index means the word lies beyond DEPTH.
  assign fault = (fetch_addr[1:0] != 2'b00) || (|fetch_addr[ADDR_WIDTH-1:IDX_W+2]);
  assign unused_base_bits = ^{load_base[1:0], load_base[ADDR_WIDTH-1:IDX_W+2]};

  assign ready      = (state == S_IDLE);
  assign load_ready = (state == S_LOAD);

  always_comb begin
    state_next = state;
    mem_we     = 1'b0;
    mem_waddr  = clr_ptr;
    mem_wdata  = NOP_WORD;
    beat       = 1'b0;
    fetch_take = 1'b0;
    case (state)
      S_CLEAR: begin
        mem_we = 1'b1;
        if (&clr_ptr) state_next = S_IDLE;
      end
      S_IDLE: begin
        fetch_take = fetch_req;
        if (load_start) state_next = S_LOAD;
      end
      S_LOAD: begin
        beat      = load_valid;
        mem_we    = load_valid;
        mem_waddr = wr_ptr;
        mem_wdata = load_data;
        if (load_valid && load_last) state_next = S_IDLE;
      end
      default: state_next = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_CLEAR;
      clr_ptr     <= '0;
      wr_ptr      <= '0;
      fetch_valid <= 1'b0;
      fetch_instr <= NOP_WORD;
      fetch_fault <= 1'b0;
      load_done   <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_CLEAR) clr_ptr <= clr_ptr + 1'b1;
      if (state == S_IDLE && load_start) wr_ptr <= load_base[IDX_W+1:2];
      else if (beat)                     wr_ptr <= wr_ptr + 1'b1;
      load_done   <= beat && load_last;
      fetch_valid <= fetch_take;
      fetch_fault <= fetch_take && fault;
      if (fetch_take) fetch_instr <= fault ? NOP_WORD : mem[fetch_idx];
    end
  end

  // Array has no reset; the CLEAR sweep is what initialises it.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem[mem_waddr] <= mem_wdata;
  end

endmodule

// File: tb/tb_prog_instruction_memory.sv
// tb/tb_prog_instruction_memory.sv - randomized self-checking bench against a word-array reference model.
module tb_prog_instruction_memory;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ready;
  logic          fetch_req = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic          fetch_valid;
  logic [DW-1:0] fetch_instr;
  logic          fetch_fault;
  logic          load_start = 1'b0;
  logic [AW-1:0] load_base = '0;
  logic          load_valid = 1'b0;
  logic [DW-1:0] load_data = '0;
  logic          load_last = 1'b0;
  logic          load_ready;
  logic          load_done;

  prog_instruction_memory #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .NOP_WORD(32'h0000_0000)
  ) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_valid(fetch_valid),
    .fetch_instr(fetch_instr), .fetch_fault(fetch_fault),
    .load_start(load_start), .load_base(load_base), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .load_done(load_done)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] words [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ref_fault(input logic [31:0] a);
    return (a % 4 != 0) || (a / 4 >= DEPTH);
  endfunction

  function automatic logic [31:0] ref_fetch(input logic [31:0] a);
    if (ref_fault(a)) return 32'h0;
    return ref_mem[int'(a / 4)];
  endfunction

  task automatic reset_and_clear();
    rst = 1'b1; fetch_req = 1'b1; fetch_addr = '0;
    load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    step(); step();
    check("rst_ready", ready, 0);
    check("rst_fetch_valid", fetch_valid, 0);
    check("rst_fetch_instr", fetch_instr, 0);
    check("rst_load_ready", load_ready, 0);
    check("rst_load_done", load_done, 0);
    rst = 1'b0;
    for (int c = 0; c < DEPTH; c++) begin
      check("clear_ready_low", ready, 0);
      check("clear_no_fetch", fetch_valid, 0);
      step();
    end
    check("clear_ready_rise", ready, 1);
    check("clear_no_fetch_end", fetch_valid, 0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    step();
    check("first_fetch_valid", fetch_valid, 1);
    check("first_fetch_instr", fetch_instr, 0);
    check("first_fetch_fault", fetch_fault, 0);
    fetch_req = 1'b0;
    step();
    check("fetch_valid_drop", fetch_valid, 0);
  endtask

  task automatic fetch_chk(input logic [31:0] a);
    logic [31:0] exp_i;
    logic        exp_f;
    exp_i = ref_fetch(a);
    exp_f = ref_fault(a);
    fetch_req = 1'b1; fetch_addr = a;
    step();
    check("fetch_valid", fetch_valid, 1);
    check("fetch_fault", fetch_fault, exp_f);
    check("fetch_instr", fetch_instr, exp_i);
  endtask

  task automatic do_load(input logic [31:0] base, input bit gaps);
    int idx;
    idx = int'((base / 4) % DEPTH);
    fetch_req = 1'b0;
    load_start = 1'b1; load_base = base;
    step();
    load_start = 1'b0;
    check("load_ready", load_ready, 1);
    check("load_not_idle", ready, 0);
    foreach (words[k]) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          load_valid = 1'b0; load_data = $urandom;
          fetch_req = 1'($urandom_range(0, 1)); fetch_addr = 32'($urandom_range(0, 15)) * 4;
          step();
          check("gap_no_fetch", fetch_valid, 0);
          check("gap_no_done", load_done, 0);
        end
        fetch_req = 1'b0;
      end
      load_valid = 1'b1; load_data = words[k]; load_last = (k == words.size() - 1);
      step();
      ref_mem[idx] = words[k];
      idx = (idx + 1) % DEPTH;
      if (k != words.size() - 1) check("beat_no_done", load_done, 0);
    end
    load_valid = 1'b0; load_last = 1'b0;
    check("load_done", load_done, 1);
    check("load_back_idle", ready, 1);
    step();
    check("load_done_pulse", load_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_and_clear();

    words.delete();
    words.push_back(32'h00221820); words.push_back(32'h2024000A); words.push_back(32'h00822824);
    do_load(32'h8, 1'b0);
    fetch_chk(32'h8); fetch_chk(32'hC); fetch_chk(32'h10);
    check("prog_word2", fetch_instr, 32'h00822824);

    fetch_chk(32'h6);
    fetch_chk(32'h40);
    fetch_chk(32'h3C);
    fetch_req = 1'b0;
    step();
    check("hold_valid_low", fetch_valid, 0);
    check("hold_instr", fetch_instr, ref_fetch(32'h3C));

    words.delete();
    words.push_back(32'hAAAA0001); words.push_back(32'hBBBB0002);
    do_load(32'h3C, 1'b1);
    fetch_chk(32'h3C);
    check("wrap_first", fetch_instr, 32'hAAAA0001);
    fetch_chk(32'h0);
    check("wrap_second", fetch_instr, 32'hBBBB0002);
    fetch_req = 1'b0;
    step();

    load_start = 1'b1; load_base = 32'h20;
    step();
    load_start = 1'b0;
    load_valid = 1'b1; load_data = 32'hDEAD0001; load_last = 1'b0;
    step();
    load_valid = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h20;
    step();
    check("load_fetch_ignored", fetch_valid, 0);
    reset_and_clear();
    fetch_chk(32'h20);
    check("reset_lost_load", fetch_instr, 32'h0);

    words.delete();
    words.push_back(32'h12345678);
    do_load(32'h8, 1'b0);
    fetch_req = 1'b1; fetch_addr = 32'h8;
    load_start = 1'b1; load_base = 32'h8;
    step();
    fetch_req = 1'b0; load_start = 1'b0;
    check("simul_fetch_valid", fetch_valid, 1);
    check("simul_fetch_instr", fetch_instr, 32'h12345678);
    check("simul_load_ready", load_ready, 1);
    load_valid = 1'b1; load_data = 32'h0BAD_F00D; load_last = 1'b1;
    step();
    ref_mem[2] = 32'h0BAD_F00D;
    load_valid = 1'b0; load_last = 1'b0;
    check("simul_load_done", load_done, 1);
    fetch_chk(32'h8);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        words.delete();
        repeat ($urandom_range(1, 5)) words.push_back($urandom);
        do_load(32'($urandom_range(0, 255)), 1'b1);
      end else begin
        repeat ($urandom_range(1, 4)) begin
          logic [31:0] a;
          a = 32'($urandom_range(0, 32'h4F));
          if ($urandom_range(0, 3) != 0) a = a & ~32'h3;
          fetch_chk(a);
        end
        fetch_req = 1'b0;
        step();
        check("burst_end_valid", fetch_valid, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_instruction_memory.md
Name: prog_instruction_memory

Overview:
Parametrised, loadable instruction memory for the single-cycle MIPS datapath and its pipelined successors.
- Adds a registered fetch port with a valid flag and fault detection.
- Adds a word-serial program-load port with an auto-incrementing write pointer.
- After reset, a hardware clear sequence fills every word with NOP, so no initial-block preload is needed.

Parameters:
DATA_WIDTH, 32, instruction word width in bits
DEPTH, 1024, number of words; must be a power of two, at least 2; IDX_W = clog2(DEPTH)
ADDR_WIDTH, 32, byte-address width of the fetch and load ports
NOP_WORD, 32'h0000_0000, fill value written during clear and returned on a fault

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
ready  output  1  high only in IDLE; fetches are accepted only when ready=1
fetch_req  input  1  fetch request, sampled at the clock edge
fetch_addr  input  ADDR_WIDTH  byte address of the instruction
fetch_valid  output  1  one-cycle pulse, one cycle after an accepted fetch
fetch_instr  output  DATA_WIDTH  fetched word; holds its value between fetches
fetch_fault  output  1  qualified by fetch_valid; misaligned or out-of-range fetch
load_start  input  1  enter load mode; accepted only in IDLE
load_base  input  ADDR_WIDTH  byte address of the first word to load
load_valid  input  1  load data beat valid
load_data  input  DATA_WIDTH  word to write
load_last  input  1  marks the final beat of the load
load_ready  output  1  high in LOAD state
load_done  output  1  one-cycle pulse in the cycle after the last beat is accepted

Behaviour:
- Reset: rst is synchronous and active-high.
  - Output values: ready=0, fetch_valid=0, fetch_instr=NOP_WORD, fetch_fault=0, load_ready=0, load_done=0.
  - State goes to CLEAR with clr_ptr=0.
  - Reset asserted in any state, including mid-load, aborts the activity and restarts CLEAR. Earlier contents are lost.
- State machine: CLEAR, IDLE, LOAD.
  - CLEAR: each cycle writes mem[clr_ptr]=NOP_WORD, then clr_ptr increments.
    - The write to index DEPTH-1 moves the FSM to IDLE.
    - ready rises exactly DEPTH cycles after the first cycle with rst=0.
    - fetch_req and load_start are ignored in CLEAR.
  - IDLE: load_start=1 moves to LOAD; wr_ptr = load_base[IDX_W+1:2].
    - load_base bits [1:0] are ignored.
    - Higher load_base bits are discarded, so the index is taken modulo DEPTH.
  - LOAD: a beat is accepted when load_valid=1 and load_ready=1.
    - An accepted beat writes mem[wr_ptr]=load_data.
    - wr_ptr then increments and wraps from DEPTH-1 to 0.
    - An accepted beat with load_last=1 writes, returns to IDLE and pulses load_done on the next cycle.
    - Cycles with load_valid=0 leave memory and wr_ptr unchanged.
- Fetch path:
  - A fetch is accepted when fetch_req=1 and state=IDLE.
  - Latency is 1 cycle: on the next cycle fetch_valid=1 and fetch_instr=mem[fetch_addr[IDX_W+1:2]].
  - Fault: fetch_addr[1:0]!=0, or fetch_addr>>2 >= DEPTH. In that case fetch_fault=1 and fetch_instr=NOP_WORD; memory is not read.
  - fetch_fault=0 on a non-faulting fetch.
  - Back-to-back fetches give one result per cycle.
  - fetch_req outside IDLE: ignored, fetch_valid=0 on the next cycle, fetch_instr holds.
- Simultaneous fetch_req and load_start in IDLE:
  - The fetch is accepted and returns the pre-load contents on the next cycle.
  - The FSM enters LOAD in the same cycle.
- There is no read-during-write hazard, because fetches and writes never share a cycle.
- The memory array is not reset directly; only CLEAR initialises it.

Test Plan:
1. DEPTH=16. Release rst, hold fetch_req=1 from cycle 0 -> fetch_valid=0 and ready=0 for cycles 0-15. ready=1 at cycle 16. The fetch of 0x0 accepted at cycle 16 returns 0x00000000 with valid at cycle 17, fault=0.
2. Load 3 beats from load_base=0x8: 0x00221820, 0x2024000A, 0x00822824, last on beat 3 -> load_done pulses once, one cycle after beat 3. Back-to-back fetches of 0x8, 0xC, 0x10 return those three words on three consecutive cycles, each exactly 1 cycle after its request.
3. Faults, DEPTH=16 -> fetch 0x6 gives fault=1 and instr=0x00000000. Fetch 0x40 gives fault=1. Fetch 0x3C gives fault=0.
4. Wrap: load_base=0x3C, beats 0xAAAA0001 then 0xBBBB0002 with last -> fetch 0x3C = 0xAAAA0001, fetch 0x0 = 0xBBBB0002. load_valid gaps between beats change nothing.
5. In LOAD, assert fetch_req -> no fetch_valid. Pulse rst after 1 of 4 beats -> ready=0 for 16 cycles, then fetching the loaded address returns 0x00000000.
6. In IDLE with mem[2]=0x12345678, drive fetch_req(addr 0x8) and load_start on the same cycle -> next cycle fetch_valid=1 with 0x12345678, and load_ready=1.
